muldiv_unit: RTL

- Iterative RV32M multiply/divide execute unit.
- Its result feeds the writeback result-select 2:1 mux; the core stalls on `busy`.
- Takes two WIDTH-bit operands plus funct3 and returns one WIDTH-bit result after a multi-cycle shift-add or restoring-divide sequence.

---
 rtl/muldiv_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply, divide unchanged.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t state;
  state_t state_n;

  logic [CW-1:0]    cnt;
  logic [2:0]       f3_q;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             neg_q;
  logic             neg_r;
  logic             spec_q;
  logic [WIDTH-1:0] spec_val;
  logic [WIDTH-1:0] result_q;

  // Operand decode happens only on the accepted-start cycle.
  logic             is_div;
  logic             a_signed;
  logic             b_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             div_ovf;
  logic             special;
  logic [WIDTH-1:0] special_res;
  logic             fast_path;

  assign is_div   = funct3[2];
  assign a_signed = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
  assign b_signed = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
  assign a_neg    = a_signed & op_a[WIDTH-1];
  assign b_neg    = b_signed & op_b[WIDTH-1];
  assign a_mag    = a_neg ? (~op_a + 1'b1) : op_a;
  assign b_mag    = b_neg ? (~op_b + 1'b1) : op_b;

  assign div_zero = is_div && (op_b == '0);
  assign div_ovf  = is_div && !funct3[0] && (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&op_b);
  assign special  = div_zero | div_ovf;

  // Divide-by-zero: quotient all ones, remainder = dividend.
  // Signed overflow: quotient = dividend (most negative value), remainder 0.
  always_comb begin
    special_res = '0;
    if (div_zero) special_res = funct3[1] ? op_a : '1;
    else          special_res = funct3[1] ? '0 : op_a;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
  assign fast_path = special | ~is_div;
`else
  assign fast_path = special;
`endif

  // One iteration of either datapath; mcand is multiplicand or divisor.
  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_sh;
  logic [WIDTH:0] div_diff;

  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, mcand};

  // Sign correction applied while in FIN.
  logic [2*WIDTH-1:0] full_prod;
  logic [2*WIDTH-1:0] full_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
  logic [WIDTH-1:0]   fin_val;

  assign full_prod = {acc_hi, acc_lo};
  assign full_fix  = neg_q ? (~full_prod + 1'b1) : full_prod;
  assign q_fix     = neg_q ? (~acc_lo + 1'b1) : acc_lo;
  assign r_fix     = neg_r ? (~acc_hi + 1'b1) : acc_hi;

  always_comb begin
    fin_val = '0;
    if (spec_q)                fin_val = spec_val;
    else if (f3_q[2])          fin_val = f3_q[1] ? r_fix : q_fix;
    else if (f3_q[1:0] == 2'b00) fin_val = full_fix[WIDTH-1:0];
    else                       fin_val = full_fix[2*WIDTH-1:WIDTH];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = fast_path ? S_FIN : S_CALC;
      S_CALC: if (cnt == CW'(1)) state_n = S_FIN;
      S_FIN:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      f3_q     <= '0;
      mcand    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      spec_q   <= 1'b0;
      spec_val <= '0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            f3_q     <= funct3;
            cnt      <= CW'(WIDTH);
            spec_q   <= special;
            spec_val <= special_res;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            mcand    <= is_div ? b_mag : a_mag;
            acc_hi   <= '0;
            acc_lo   <= is_div ? a_mag : b_mag;
`ifdef MULDIV_FAST_MUL_EN
            if (!is_div) {acc_hi, acc_lo} <= fast_prod;
`endif
          end
        end
        S_CALC: begin
          cnt <= cnt - 1'b1;
          if (f3_q[2]) begin
            acc_hi <= div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        S_FIN: result_q <= fin_val;
        default: ;
      endcase
    end
  end

  // The corrected value is presented combinationally in FIN, then held.
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_FIN);
  assign result = (state == S_FIN) ? fin_val : result_q;

endmodule
